conv_result_drain: RTL

- Downstream stage of the convolution core. Once the core finishes, this block reads the result memory (memZ) sequentially.
- Each result word is emitted on a valid/ready output stream, with a last flag on the final word.
- It accepts back-pressure without losing or duplicating words, and reports busy/done to the control wrapper.
- `start_in` is normally driven by the convolution core's done pulse.

---
 rtl/conv_result_drain.sv | 134 +++++++++++++
 1 files changed

// File: rtl/conv_result_drain.sv
// Result drain: reads memZ in address order and streams each word out
// on a valid/ready port, with last on the final word and busy/done status.
module conv_result_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_in,
  input  logic [2*ADDR_WIDTH-1:0] config_in,
  output logic [ADDR_WIDTH:0]     memZ_addr,
  output logic                    memZ_rd,
  input  logic [2*DATA_WIDTH-1:0] dataZ_in,
  output logic [2*DATA_WIDTH-1:0] m_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic                    busy_out,
  output logic                    done_out
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int DW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t                state;
  logic [CW-1:0]         n_words;
  logic [CW-1:0]         n_cfg;
  logic [CW-1:0]         rd_cnt;
  logic [CW-1:0]         out_cnt;
  logic [ADDR_WIDTH-1:0] size_x;
  logic [ADDR_WIDTH-1:0] size_y;
  logic                  inflight;
  logic                  t_valid;
  logic [DW-1:0]         t_data;
  logic                  pop;
  logic                  push;
  logic [1:0]            level;

  assign size_x = config_in[ADDR_WIDTH-1:0];
  assign size_y = config_in[2*ADDR_WIDTH-1:ADDR_WIDTH];

  assign n_cfg = (size_x == '0 || size_y == '0) ? '0 :
                 CW'(size_x) + CW'(size_y) - CW'(1);

  assign pop  = m_valid & m_ready;
  assign push = inflight;

  // Occupancy after this cycle's pop, counting the word still in flight.
  assign level = {1'b0, m_valid} + {1'b0, t_valid}
               + {1'b0, inflight} - {1'b0, pop};

  assign memZ_rd   = (state == RUN) && (rd_cnt < n_words)
                   && (level < 2'd2);
  assign memZ_addr = memZ_rd ? rd_cnt : '0;
  assign m_last    = m_valid && (out_cnt == n_words - CW'(1));

  // Two-entry FIFO: head register drives the stream, tail absorbs stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      t_valid  <= 1'b0;
      t_data   <= '0;
    end else begin
      inflight <= memZ_rd;
      if (pop) begin
        if (t_valid) begin
          m_data  <= t_data;
          t_valid <= push;
          if (push) t_data <= dataZ_in;
        end else begin
          m_valid <= push;
          if (push) m_data <= dataZ_in;
        end
      end else if (push) begin
        if (!m_valid) begin
          m_valid <= 1'b1;
          m_data  <= dataZ_in;
        end else begin
          t_valid <= 1'b1;
          t_data  <= dataZ_in;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      n_words  <= '0;
      rd_cnt   <= '0;
      out_cnt  <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_in) begin
            n_words  <= n_cfg;
            rd_cnt   <= '0;
            out_cnt  <= '0;
            busy_out <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (memZ_rd) rd_cnt <= rd_cnt + CW'(1);
          if (pop) out_cnt <= out_cnt + CW'(1);
          // An empty drain spends one cycle here so done lands at t+2.
          if (n_words == '0 || (pop && m_last)) begin
            state    <= FINISH;
            done_out <= 1'b1;
            busy_out <= 1'b0;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rstn) !(push && !pop && t_valid)
  );

endmodule
